mux16_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 16:1 single-bit mux path. Sixteen requesters each own one mux input. The block decides which requester owns the path, drives the 4-bit select, holds it for the duration of a transfer, and rotates priority fairly afterwards. It sits directly in front of the 16:1 mux and is the only driver of its select lines.

---
 rtl/mux16_arb_pkg.sv | 13 +
 rtl/rr_pick16.sv | 25 ++
 rtl/mux16_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux16_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux16_arb_pkg.sv
// Shared constants and state encoding for the 16:1 mux round-robin arbiter.
package mux16_arb_pkg;

  localparam int unsigned NUM_REQ    = 16;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick16.sv
// Round-robin winner picker: first requester at or after ptr, wrapping mod 16.
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    winner  = off + ptr;
    any_req = |req;
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the select of a shared 16:1 mux.
// Optional hold-limit release is compiled in with MUX16_ARB_TIMEOUT_EN.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  input  logic [NUM_REQ-1:0] data_in,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               y,
  output logic               timeout
);

  arb_state_e       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner_c;
  logic             any_req_c;
  logic             norm_rel_c;
  logic             hold_hit_c;
  logic             force_rel_c;
  logic             release_c;

  rr_pick16 u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner_c),
    .any_req (any_req_c)
  );

`ifdef MUX16_ARB_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_cnt;

  // Counts GRANT cycles of the current grant, starting at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      hold_cnt <= any_req_c ? HOLD_CNT_W'(1) : '0;
    end else if (release_c) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
    end
  end

  assign hold_hit_c = (hold_cnt == HOLD_CNT_W'(HOLD_MAX));
`else
  logic unused_hold_max;
  assign unused_hold_max = ^HOLD_CNT_W'(HOLD_MAX);
  assign hold_hit_c      = 1'b0;
`endif

  // Release causes; the hold limit only counts when nothing else releases.
  assign norm_rel_c  = done | ~req[sel];
  assign force_rel_c = hold_hit_c & ~norm_rel_c;
  assign release_c   = norm_rel_c | force_rel_c;

  // Arbitration FSM with registered select, grant, busy and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      sel     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req_c) begin
            state <= ARB_GRANT;
            sel   <= winner_c;
            gnt   <= NUM_REQ'(1) << winner_c;
            busy  <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (release_c) begin
            state   <= ARB_IDLE;
            ptr     <= sel + SEL_W'(1);
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= force_rel_c;
          end
        end
        default: begin
          state <= ARB_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Mux output; sel is frozen for the whole grant so this cannot glitch on select.
  assign y = busy & data_in[sel];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus random
// traffic, checked every cycle against a behavioural round-robin model.
module tb_mux16_rr_arbiter;

`ifdef MUX16_ARB_TIMEOUT_EN
  localparam int TB_HOLD = 4;
  localparam bit TB_TO   = 1'b1;
`else
  localparam int TB_HOLD = 8;
  localparam bit TB_TO   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        y;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  mux16_rr_arbiter #(.HOLD_MAX(TB_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .data_in (data_in),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .y       (y),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: who holds the path, priority pointer, cycles held.
  bit m_busy = 0;
  int m_sel  = 0;
  int m_ptr  = 0;
  int m_hold = 0;
  bit m_to   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (req != 16'h0) begin
          bit found;
          found = 0;
          for (int k = 0; k < 16; k++) begin
            if (!found && req[(m_ptr + k) % 16]) begin
              m_sel = (m_ptr + k) % 16;
              found = 1;
            end
          end
          m_busy = 1;
          m_hold = 1;
        end
      end else begin
        bit normal, forced;
        normal = done || !req[m_sel];
        forced = TB_TO && (m_hold == TB_HOLD) && !normal;
        if (normal || forced) begin
          m_busy = 0;
          m_ptr  = (m_sel + 1) % 16;
          m_to   = forced;
          m_hold = 0;
        end else begin
          m_hold = m_hold + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [15:0] e_gnt;
    logic        e_y;
    e_gnt = m_busy ? (16'h1 << m_sel) : 16'h0;
    e_y   = m_busy ? data_in[m_sel] : 1'b0;
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_gnt", 32'(gnt), 32'(e_gnt));
    chk("cyc_sel", 32'(sel), 32'(m_sel));
    chk("cyc_y", 32'(y), 32'(e_y));
    chk("cyc_timeout", 32'(timeout), 32'(m_to));
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  logic [15:0] y_exp;
  initial y_exp = 16'b0101_0100_0100_0001;  // bit k is y for sel=k

  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (3) tick();
    look();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    rst_n = 1'b1;

    // Reset in the middle of a grant to requester 5
    data_in = 16'h0020;
    req = 16'h0020;
    tick(); look();
    chk("g5_gnt", 32'(gnt), 32'h0020);
    chk("g5_sel", 32'(sel), 32'h5);
    chk("g5_y", 32'(y), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_y", 32'(y), 32'h0);
    req = 16'h0;
    tick(); look();
    rst_n = 1'b1;
    chk("mid_rst_ptr", 32'(dut.ptr), 32'h0);

    // Full rotation with data path check and one IDLE cycle between grants
    data_in = 16'h5441;
    req = 16'hFFFF;
    tick(); look();
    for (int i = 0; i <= 16; i++) begin
      chk("rot_sel", 32'(sel), 32'(i % 16));
      chk("rot_gnt", 32'(gnt), 32'(16'h1 << (i % 16)));
      chk("rot_y", 32'(y), 32'(y_exp[i % 16]));
      done = 1'b1;
      tick();
      done = 1'b0;
      look();
      chk("rot_idle_busy", 32'(busy), 32'h0);
      chk("rot_idle_y", 32'(y), 32'h0);
      tick(); look();
    end

    // Wrap priority: release 14, then 15 beats 0, then 0
    chk("pre_wrap_sel", 32'(sel), 32'h1);
    req = 16'h4000;
    tick(); look();
    chk("wrap_rel_busy", 32'(busy), 32'h0);
    tick(); look();
    chk("wrap_g14", 32'(sel), 32'd14);
    done = 1'b1;
    req = 16'h8001;
    tick();
    done = 1'b0;
    look();
    chk("wrap_ptr15", 32'(dut.ptr), 32'd15);
    tick(); look();
    chk("wrap_g15", 32'(sel), 32'd15);
    done = 1'b1;
    tick();
    done = 1'b0;
    look();
    tick(); look();
    chk("wrap_g0", 32'(sel), 32'd0);
    done = 1'b1;
    req = 16'h0;
    tick();
    done = 1'b0;
    look();
    chk("wrap_ptr1", 32'(dut.ptr), 32'd1);

    // Requester drop releases without done
    req = 16'h0008;
    tick(); look();
    chk("drop_g3", 32'(gnt), 32'h0008);
    req = 16'h0;
    tick(); look();
    chk("drop_gnt", 32'(gnt), 32'h0);
    chk("drop_ptr", 32'(dut.ptr), 32'h4);

    // Single requester held with no done: hold limit or unbounded grant
    req = 16'h0004;
    tick(); look();
`ifdef MUX16_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      chk("to_hold_gnt", 32'(gnt), 32'h0004);
      chk("to_hold_pulse", 32'(timeout), 32'h0);
      tick(); look();
    end
    chk("to_rel_gnt", 32'(gnt), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    tick(); look();
    chk("to_regrant", 32'(gnt), 32'h0004);
    chk("to_pulse_end", 32'(timeout), 32'h0);
`else
    for (int c = 0; c < 20; c++) begin
      chk("nto_hold_gnt", 32'(gnt), 32'h0004);
      chk("nto_timeout", 32'(timeout), 32'h0);
      tick(); look();
    end
`endif
    req = 16'h0;
    tick(); look();
    guard = 0;
    while (busy && guard < 20) begin
      tick(); look(); guard++;
    end
    chk("drain_idle", 32'(busy), 32'h0);

    // Random traffic checked by the per-cycle model comparison
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: req = 16'h0;
          1: req = 16'hFFFF;
          2: req = 16'h1 << $urandom_range(0, 15);
          default: req = 16'($urandom);
        endcase
      end
      done = ($urandom_range(0, 5) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    done = 1'b0;
    req = 16'h0;
    tick(); tick();
    look();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
